// File: rtl/sram_nrnw_pipe.sv
// Multi-port register-file SRAM: NUM_RD registered read ports with write-first bypass,
// NUM_WR write ports with fixed priority on collisions, and a post-reset clear sweep.
module sram_nrnw_pipe #(
    parameter int unsigned SRAM_DEPTH   = 128,
    parameter int unsigned SRAM_INDEX   = 7,
    parameter int unsigned SRAM_WIDTH   = 32,
    parameter int unsigned NUM_RD       = 12,
    parameter int unsigned NUM_WR       = 6,
    parameter int unsigned CLR_ON_RESET = 1,
    parameter int unsigned CLR_BASE     = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0]              rd_en_i,
    input  logic [NUM_RD*SRAM_INDEX-1:0]   rd_addr_i,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR*SRAM_INDEX-1:0]   wr_addr_i,
    input  logic [NUM_WR*SRAM_WIDTH-1:0]   wr_data_i,
    output logic [NUM_RD*SRAM_WIDTH-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]              rd_valid_o,
    output logic                           ready_o,
    output logic                           wr_conflict_o
);

    localparam int unsigned AW1 = SRAM_INDEX + 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                  state, state_nxt;
    logic [SRAM_INDEX-1:0]   clr_ptr;
    logic                    clr_last;
    logic                    clr_we, acc_en, ready_d, conflict_d;

    logic [SRAM_WIDTH-1:0]   mem     [SRAM_DEPTH];
    logic [SRAM_INDEX-1:0]   wr_addr [NUM_WR];
    logic [SRAM_WIDTH-1:0]   wr_data [NUM_WR];
    logic [NUM_WR-1:0]       wr_ok;
    logic [SRAM_INDEX-1:0]   rd_addr [NUM_RD];
    logic [SRAM_WIDTH-1:0]   rd_next [NUM_RD];
    logic [NUM_RD-1:0]       rd_fire;

    function automatic logic in_range(input logic [SRAM_INDEX-1:0] a);
        return {1'b0, a} < AW1'(SRAM_DEPTH);
    endfunction

    assign clr_last = (clr_ptr == SRAM_INDEX'(SRAM_DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = RST_STATE;
        endcase
    end

    // Per-state controls; gated by reset so no array write lands while reset is held
    always_comb begin
        clr_we  = 1'b0;
        acc_en  = 1'b0;
        ready_d = 1'b0;
        case (state)
            ST_CLEAR: clr_we = reset;
            ST_RUN: begin
                acc_en  = reset;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      clr_ptr <= SRAM_INDEX'(CLR_BASE);
        else if (clr_we) clr_ptr <= clr_ptr + SRAM_INDEX'(1);
    end

    // Unpack ports and qualify writes
    always_comb begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wr_addr[w] = wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX];
            wr_data[w] = wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH];
            wr_ok[w]   = acc_en && we_i[w] && in_range(wr_addr[w]);
        end
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            rd_addr[r] = rd_addr_i[r*SRAM_INDEX +: SRAM_INDEX];
            rd_fire[r] = acc_en && rd_en_i[r];
        end
    end

    // Write-first read value: later (higher-numbered) write ports override earlier ones
    always_comb begin
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            rd_next[r] = in_range(rd_addr[r]) ? mem[rd_addr[r]] : '0;
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wr_addr[w] == rd_addr[r])) rd_next[r] = wr_data[w];
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                if (wr_ok[i] && wr_ok[j] && (wr_addr[i] == wr_addr[j])) conflict_d = 1'b1;
            end
        end
    end

    // Array storage is not reset; the clear sweep zeroes it
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_ptr] <= '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) mem[wr_addr[w]] <= wr_data[w];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_o       <= 1'b0;
            wr_conflict_o <= 1'b0;
            rd_valid_o    <= '0;
            rd_data_o     <= '0;
        end else begin
            ready_o       <= ready_d;
            wr_conflict_o <= conflict_d;
            rd_valid_o    <= rd_fire;
            for (int unsigned r = 0; r < NUM_RD; r++) begin
                if (rd_fire[r]) rd_data_o[r*SRAM_WIDTH +: SRAM_WIDTH] <= rd_next[r];
            end
        end
    end

endmodule

// File: doc/sram_nrnw_pipe.md
# sram_nrnw_pipe

Parametrised multi-port register-file SRAM with NUM_RD read ports and NUM_WR write ports. Reads are registered, with one-cycle latency and write-first bypass. Same-address write collisions resolve by fixed priority and are flagged. A hardware clear sequencer zeroes the array after reset. It replaces the fixed 12-read/6-write combinational-read register file in the physical register file and issue-queue payload RAMs.

## Interface
- SRAM_DEPTH, 128, number of entries
- SRAM_INDEX, 7, address width; SRAM_DEPTH ≤ 2^SRAM_INDEX
- SRAM_WIDTH, 32, entry width
- NUM_RD, 12, read ports (≥1)
- NUM_WR, 6, write ports (≥1)
- CLR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = no clear
- CLR_BASE, 0, first entry cleared; entries below CLR_BASE are never cleared

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*SRAM_INDEX  port k address in bits [k*SRAM_INDEX +: SRAM_INDEX]
- we_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR*SRAM_INDEX  port k write address, packed as for rd_addr_i
- wr_data_i  in  NUM_WR*SRAM_WIDTH  port k data in [k*SRAM_WIDTH +: SRAM_WIDTH]
- rd_data_o  out  NUM_RD*SRAM_WIDTH  registered read data, packed per port
- rd_valid_o  out  NUM_RD  port k read data valid this cycle
- ready_o  out  1  array accepting accesses
- wr_conflict_o  out  1  one-cycle pulse: two or more enabled write ports hit the same address in the previous cycle

## Operation
- FSM states: CLEAR and RUN.
- While reset is low:
  - State is CLEAR if CLR_ON_RESET=1, otherwise RUN.
  - clr_ptr = CLR_BASE.
  - All outputs read 0: ready_o, rd_valid_o, rd_data_o, wr_conflict_o.
  - Array contents are not reset asynchronously.
- CLEAR:
  - Each edge writes 0 to sram[clr_ptr], then increments clr_ptr.
  - After the write to SRAM_DEPTH-1, the next state is RUN.
  - we_i and rd_en_i are ignored. rd_valid_o stays 0 and ready_o stays 0.
- RUN:
  - ready_o = 1.
  - Each port k with we_i[k]=1 writes its data at the edge.
  - On an address collision, the highest-numbered enabled port wins. wr_conflict_o = 1 on the following cycle only.
- Reads in RUN:
  - A port with rd_en_i[k]=1 samples its address at edge t.
  - rd_data_o[k] presents the entry value after edge t's writes are applied (write-first bypass, including collision priority).
  - rd_valid_o[k] = 1 for that cycle.
  - With rd_en_i[k]=0, rd_data_o[k] holds its last value and rd_valid_o[k]=0.
- Out-of-range address (≥ SRAM_DEPTH): the write is dropped and the read returns 0. It is not a conflict.
- Reset asserted mid-clear or mid-run:
  - All outputs go to 0 immediately.
  - Writes in flight are lost.
  - The clear sweep restarts from CLR_BASE after release.

## Timing
- Read latency: 1 cycle, from address sample edge to rd_data_o valid.
- Write-to-read: a write and a read to the same address at the same edge return the new data.
- Clear duration: SRAM_DEPTH-CLR_BASE cycles after the first rising edge following reset release. ready_o rises on the next edge.
- CLR_ON_RESET=0: ready_o rises at the first edge after release.
- wr_conflict_o: registered, asserted one cycle after the colliding edge, high for exactly 1 cycle per colliding edge.
- No combinational path from any input to any output.

## Test plan
- Clear sweep, SRAM_DEPTH=128, CLR_BASE=0: release reset, count edges -> ready_o=0 for 128 edges and 1 from edge 129. Reading every entry returns 0x00000000.
- Bypass: write 0xDEADBEEF to addr 5 on port 0 while port 3 reads addr 5 at the same edge -> next cycle rd_data_o[3]=0xDEADBEEF, rd_valid_o[3]=1.
- Collision: ports 1 and 4 write 0x11 and 0x44 to addr 9 -> wr_conflict_o=1 for one cycle. Reading addr 9 returns 0x44.
- Hold: read addr 2 (=0x77), then drop rd_en_i -> rd_data_o stays 0x77 and rd_valid_o=0.
- Reset mid-clear at clr_ptr=60 -> outputs go to 0 immediately. After release, the sweep runs the full 128 cycles again.
- Ignore during clear: we_i=1 to addr 127 during CLEAR -> reading addr 127 after ready_o returns 0.
